xor_change_monitor: RTL and testbench



---
 rtl/xor_change_monitor_pkg.sv | 14 +
 rtl/xor_change_monitor_if.sv | 24 ++
 rtl/xor_change_monitor_sat_counter.sv | 42 ++++
 rtl/xor_change_monitor.sv | 83 ++++++++
 tb/tb_xor_change_monitor.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/xor_change_monitor_pkg.sv
// Shared definitions for the XOR change monitor: FSM encoding and counter limit helper.
package xor_mon_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    // Computed in 64 bits so the shift stays defined for any counter width up to 63.
    function automatic longint unsigned cnt_max(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/xor_change_monitor_if.sv
// Sample/report bundle between a driver and one xor_change_monitor instance.
interface xor_change_monitor_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 4
);
    logic             en;
    logic             clr;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] chg;
    logic             chg_any;
    logic [CNT_W-1:0] cnt;
    logic             sat;

    modport master (
        output en, clr, b,
        input  a, chg, chg_any, cnt, sat
    );

    modport slave (
        input  en, clr, b,
        output a, chg, chg_any, cnt, sat
    );
endinterface

// File: rtl/xor_change_monitor_sat_counter.sv
// Saturating event counter with synchronous clear; sat flags the terminal value.
module sat_counter
    import xor_mon_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         sat
);
    localparam logic [W-1:0] CNT_MAX = W'(cnt_max(W));

    logic [W-1:0] cnt_q, cnt_d;
    logic         sat_q, sat_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
        // Once at max the count holds, so sat stays set until clr or reset.
        sat_d = (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign cnt = cnt_q;
    assign sat = sat_q;
endmodule

// File: rtl/xor_change_monitor.sv
// Registered b ^ MASK with per-bit change detection against the last enabled sample.
module xor_change_monitor
    import xor_mon_pkg::*;
#(
    parameter int               WIDTH = 1,
    parameter logic [WIDTH-1:0] MASK  = '0,
    parameter int               CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    xor_change_monitor_if.slave  mon
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] chg_q, chg_d;
    logic             chg_any_q, chg_any_d;
    logic [WIDTH-1:0] diff;
    logic             inc;

    always_comb begin
        diff      = mon.b ^ prev_q;
        state_d   = state_q;
        prev_d    = prev_q;
        a_d       = a_q;
        chg_d     = '0;
        chg_any_d = 1'b0;
        inc       = 1'b0;
        // clr drops change history, so the next enabled sample only re-primes.
        if (mon.clr) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mon.en) begin
                        prev_d  = mon.b;
                        a_d     = mon.b ^ MASK;
                        state_d = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (mon.en) begin
                        chg_d     = diff;
                        chg_any_d = |diff;
                        prev_d    = mon.b;
                        a_d       = mon.b ^ MASK;
                        inc       = |diff;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            prev_q    <= '0;
            a_q       <= '0;
            chg_q     <= '0;
            chg_any_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            a_q       <= a_d;
            chg_q     <= chg_d;
            chg_any_q <= chg_any_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mon.clr),
        .inc   (inc),
        .cnt   (mon.cnt),
        .sat   (mon.sat)
    );

    assign mon.a       = a_q;
    assign mon.chg     = chg_q;
    assign mon.chg_any = chg_any_q;
endmodule

// File: tb/tb_xor_change_monitor.sv
// Directed vector bench: one 2-bit instance driven from a table, 3-bit and 1-bit instances by hand.
module tb_xor_change_monitor;
    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    xor_change_monitor_if #(.WIDTH(2), .CNT_W(2)) if2 ();
    xor_change_monitor_if #(.WIDTH(3), .CNT_W(4)) if3 ();
    xor_change_monitor_if #(.WIDTH(1), .CNT_W(4)) if1 ();

    xor_change_monitor #(.WIDTH(2), .MASK(2'b00), .CNT_W(2)) u2 (
        .clk(clk), .rst_n(rst_n), .mon(if2));
    xor_change_monitor #(.WIDTH(3), .MASK(3'b101), .CNT_W(4)) u3 (
        .clk(clk), .rst_n(rst_n), .mon(if3));
    xor_change_monitor #(.WIDTH(1), .CNT_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .mon(if1));

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       clr;
        logic [1:0] b;
        logic [1:0] a;
        logic [1:0] chg;
        logic       any;
        logic [1:0] cnt;
        logic       sat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic e, input logic c, input logic [1:0] b,
                       input logic [1:0] a, input logic [1:0] ch, input logic an,
                       input logic [1:0] cn, input logic s);
        vec_t v;
        v.rst_n = r; v.en = e; v.clr = c; v.b = b;
        v.a = a; v.chg = ch; v.any = an; v.cnt = cn; v.sat = s;
        vecs.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0;
        if2.en = 1'b0; if2.clr = 1'b0; if2.b = '0;
        if3.en = 1'b0; if3.clr = 1'b0; if3.b = '0;
        if1.en = 1'b0; if1.clr = 1'b0; if1.b = '0;

        //  rst en clr  b     | a     chg   any cnt sat
        add(0, 1, 0, 2'b00,   2'b00, 2'b00, 0, 0, 0);  // reset holds zeros
        add(0, 1, 0, 2'b11,   2'b00, 2'b00, 0, 0, 0);
        add(0, 1, 1, 2'b00,   2'b00, 2'b00, 0, 0, 0);  // reset beats clr
        add(1, 0, 0, 2'b11,   2'b00, 2'b00, 0, 0, 0);  // idle, en=0 holds a
        add(1, 1, 0, 2'b01,   2'b01, 2'b00, 0, 0, 0);  // prime
        add(1, 1, 0, 2'b10,   2'b10, 2'b11, 1, 1, 0);
        add(1, 1, 0, 2'b10,   2'b10, 2'b00, 0, 1, 0);
        add(1, 1, 0, 2'b01,   2'b01, 2'b11, 1, 2, 0);
        add(1, 0, 0, 2'b01,   2'b01, 2'b00, 0, 2, 0);  // enable gap
        add(1, 0, 0, 2'b11,   2'b01, 2'b00, 0, 2, 0);
        add(1, 0, 0, 2'b00,   2'b01, 2'b00, 0, 2, 0);
        add(1, 1, 0, 2'b00,   2'b00, 2'b01, 1, 3, 1);  // gap change reported, saturates
        add(1, 1, 0, 2'b11,   2'b11, 2'b11, 1, 3, 1);  // no wrap at max
        add(1, 1, 1, 2'b00,   2'b11, 2'b00, 0, 0, 0);  // clr wins over en
        add(1, 1, 0, 2'b01,   2'b01, 2'b00, 0, 0, 0);  // re-prime, no report
        add(1, 1, 0, 2'b10,   2'b10, 2'b11, 1, 1, 0);
        add(1, 1, 0, 2'b01,   2'b01, 2'b11, 1, 2, 0);
        add(1, 1, 0, 2'b10,   2'b10, 2'b11, 1, 3, 1);
        add(1, 1, 0, 2'b01,   2'b01, 2'b11, 1, 3, 1);
        add(1, 1, 0, 2'b10,   2'b10, 2'b11, 1, 3, 1);
        add(1, 1, 0, 2'b01,   2'b01, 2'b11, 1, 3, 1);
        add(1, 1, 1, 2'b11,   2'b01, 2'b00, 0, 0, 0);  // clr during change
        add(1, 1, 0, 2'b10,   2'b10, 2'b00, 0, 0, 0);
        add(1, 1, 0, 2'b10,   2'b10, 2'b00, 0, 0, 0);
        add(1, 1, 0, 2'b11,   2'b11, 2'b01, 1, 1, 0);
        add(1, 0, 1, 2'b00,   2'b11, 2'b00, 0, 0, 0);  // clr with en=0
        add(1, 1, 0, 2'b00,   2'b00, 2'b00, 0, 0, 0);
        add(0, 1, 0, 2'b10,   2'b00, 2'b00, 0, 0, 0);  // mid-run reset

        #1;
        foreach (vecs[i]) begin
            rst_n   = vecs[i].rst_n;
            if2.en  = vecs[i].en;
            if2.clr = vecs[i].clr;
            if2.b   = vecs[i].b;
            tick();
            check($sformatf("v%0d.a", i),       32'(if2.a),       32'(vecs[i].a));
            check($sformatf("v%0d.chg", i),     32'(if2.chg),     32'(vecs[i].chg));
            check($sformatf("v%0d.chg_any", i), 32'(if2.chg_any), 32'(vecs[i].any));
            check($sformatf("v%0d.cnt", i),     32'(if2.cnt),     32'(vecs[i].cnt));
            check($sformatf("v%0d.sat", i),     32'(if2.sat),     32'(vecs[i].sat));
        end

        check("w3.reset.a", 32'(if3.a), 32'h0);
        check("w1.reset.cnt", 32'(if1.cnt), 32'h0);

        rst_n  = 1'b1;
        if2.en = 1'b0;
        if3.en = 1'b1; if3.b = 3'b000;
        if1.en = 1'b1; if1.b = 1'b0;
        tick();
        check("w3.prime.a", 32'(if3.a), 32'h5);
        check("w3.prime.chg", 32'(if3.chg), 32'h0);
        check("w3.prime.cnt", 32'(if3.cnt), 32'h0);
        check("w1.prime.a", 32'(if1.a), 32'h0);
        check("w1.prime.chg_any", 32'(if1.chg_any), 32'h0);

        if3.b = 3'b111; if1.b = 1'b1;
        tick();
        check("w3.s1.a", 32'(if3.a), 32'h2);
        check("w3.s1.chg", 32'(if3.chg), 32'h7);
        check("w3.s1.chg_any", 32'(if3.chg_any), 32'h1);
        check("w3.s1.cnt", 32'(if3.cnt), 32'h1);
        check("w1.s1.a", 32'(if1.a), 32'h1);
        check("w1.s1.chg", 32'(if1.chg), 32'h1);
        check("w1.s1.cnt", 32'(if1.cnt), 32'h1);

        if1.b = 1'b0;
        tick();
        check("w3.s2.chg", 32'(if3.chg), 32'h0);
        check("w3.s2.cnt", 32'(if3.cnt), 32'h1);
        check("w1.s2.chg", 32'(if1.chg), 32'h1);
        check("w1.s2.cnt", 32'(if1.cnt), 32'h2);

        if1.b = 1'b1;
        tick();
        check("w3.s3.cnt", 32'(if3.cnt), 32'h1);
        check("w1.s3.cnt", 32'(if1.cnt), 32'h3);
        check("w1.s3.sat", 32'(if1.sat), 32'h0);
        check("w1.s3.a", 32'(if1.a), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
